mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one transaction in
// flight, alternating priority, registered completion pulse and read data.

module mem_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              serve,
  input  logic              rd,
  input  logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  // done follows serve by one cycle; rdata only moves on this port's reads
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= serve;
      if (serve && rd) rdata <= read_data;
    end
  end

endmodule

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData
);

  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t state, state_nxt;
  logic   prio;
  req_t   lat;
  logic   grant, grant_sel, in_serve;

  req_t [NUM_PORTS-1:0]             port_req;
  logic [NUM_PORTS-1:0]             req_vec, serve, done;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  assign port_req[0] = {We0, Addr0, WData0};
  assign port_req[1] = {We1, Addr1, WData1};
  assign req_vec     = {Req1, Req0};

  // The serving port's own Req is ignored at the end of its SERVE, so a
  // continuously requesting peer always gets the next slot.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req_vec[0] && (!req_vec[1] || !prio)) state_nxt = SERVE0;
        else if (req_vec[1])                      state_nxt = SERVE1;
      end
      SERVE0:  if (req_vec[1]) state_nxt = SERVE1;
      SERVE1:  if (req_vec[0]) state_nxt = SERVE0;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant     = (state_nxt != IDLE);
  assign grant_sel = (state_nxt == SERVE1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        prio <= ~grant_sel;
        lat  <= port_req[grant_sel];
      end
    end
  end

  assign serve[0] = (state == SERVE0);
  assign serve[1] = (state == SERVE1);
  assign in_serve = |serve;

  // Memory strobes decode straight from state so reset kills them at once
  assign Address   = in_serve ? lat.addr  : '0;
  assign WriteData = in_serve ? lat.wdata : '0;
  assign MemWrite  = in_serve &  lat.we;
  assign MemRead   = in_serve & ~lat.we;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .serve    (serve[p]),
      .rd       (~lat.we),
      .read_data(ReadData),
      .done     (done[p]),
      .rdata    (rdata[p])
    );
  end

  assign Gnt0   = serve[0];
  assign Gnt1   = serve[1];
  assign Done0  = done[0];
  assign Done1  = done[1];
  assign RData0 = rdata[0];
  assign RData1 = rdata[1];

endmodule
